// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI-Lite CPU bridge and its neighbours.
package axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_B,
        READ_AR,
        READ_R,
        DRAIN
    } state_e;

    localparam logic [1:0]  RESP_OKAY         = 2'b00;
    localparam logic [1:0]  RESP_SLVERR       = 2'b10;
    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/axil_cpu_bridge_if.sv
// AXI-Lite channel bundle (no bresp: the attached slave always answers OKAY).
interface axil_cpu_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axil_timeout_counter.sv
// Saturating watchdog: counts enabled cycles since load, expire_o once the
// budget is used up; TIMEOUT_CYCLES = 0 never expires.
module axil_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic load_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int            CW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] count_q, count_d;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = CW'(1);  // the acceptance cycle itself counts as elapsed
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (count_q >= LIMIT);

endmodule

// File: rtl/axil_cpu_bridge.sv
// Converts a PicoRV32-style valid/ready memory port into single-outstanding
// AXI-Lite transactions, with a response watchdog and a sticky error flag.
module axil_cpu_bridge
    import axil_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [STRB_WIDTH-1:0] mem_wstrb,
    output logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  bus_error,
    input  logic                  err_clr,
    axil_cpu_bridge_if.master     m_axil
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d;
    logic                  mem_ready_q, mem_ready_d, bus_error_q, bus_error_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  accept, err_set, tmo_expire, tmo_fire;

    assign aw_hs    = awvalid_q & m_axil.awready;
    assign w_hs     = wvalid_q  & m_axil.wready;
    assign b_hs     = bready_q  & m_axil.bvalid;
    assign ar_hs    = arvalid_q & m_axil.arready;
    assign r_hs     = rready_q  & m_axil.rvalid;
    assign accept   = (state_q == IDLE) && mem_valid && !mem_ready_q;
    assign tmo_fire = tmo_expire && (state_q != DRAIN);

    axil_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load_i   (accept),
        .clear_i  ((state_q != IDLE) && (state_d == IDLE)),
        .en_i     (state_q != IDLE),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        err_set     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    if (mem_wstrb != '0) begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = READ_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WAIT_B;
                    bready_d = 1'b1;
                end
            end
            WAIT_B: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            READ_AR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = READ_R;
                end
            end
            READ_R: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    mem_rdata_d = m_axil.rdata;
                    mem_ready_d = 1'b1;
                    err_set     = (m_axil.rresp != RESP_OKAY);
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (ar_hs) arvalid_d = 1'b0;
                if (b_hs || r_hs) begin
                    bready_d = 1'b0;
                    rready_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A handshake that makes progress in the expiring cycle wins over the
        // timeout; the saturated counter re-fires in the following state.
        if (tmo_fire && (state_d == state_q)) begin
            state_d     = DRAIN;
            mem_ready_d = 1'b1;
            err_set     = 1'b1;
            if (wstrb_q == '0) begin
                rready_d    = 1'b1;
                mem_rdata_d = ERR_RDATA;
            end else begin
                bready_d = 1'b1;
            end
        end

        bus_error_d = err_set ? 1'b1 : (err_clr ? 1'b0 : bus_error_q);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign m_axil.awaddr  = addr_q;
    assign m_axil.araddr  = addr_q;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = wstrb_q;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.bready  = bready_q;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.rready  = rready_q;
    assign mem_ready      = mem_ready_q;
    assign mem_rdata      = mem_rdata_q;
    assign bus_error      = bus_error_q;

endmodule
